d_ip_timer_cnt_ref_checker: RTL

- Parametrised, multi-channel successor to the timer IP checker. Contains a cycle-accurate reference model of each timer counter channel, including init load, min/max window, up/down direction and wrap/overflow.
- Compares the DUT counter value and overflow pulse against the model every cycle. Reports per-channel mismatch pulses, sticky status and a saturating error count.
- Bound alongside the timer DUT in the testbench. Fully synthesizable so it can also be used in emulation.

---
 rtl/d_ip_timer_cnt_ref_checker.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/d_ip_timer_cnt_ref_checker.sv
// Multi-channel cycle-accurate reference checker for the timer counter IP.
// Define D_IP_TIMER_CHK_SVA_EN to compile per-channel assertions and overflow covers.

module d_ip_timer_cnt_ref_chan #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             check,
  input  logic             en,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] init,
  input  logic [WIDTH-1:0] min_v,
  input  logic [WIDTH-1:0] max_v,
  input  logic [WIDTH-1:0] dut_cnt,
  input  logic             dut_ovf,
  output logic [WIDTH-1:0] exp_cnt,
  output logic             exp_ovf,
  output logic             cfg_bad,
  output logic             mis_cnt,
  output logic             mis_ovf,
  output logic             err_cnt,
  output logic             err_ovf
);
  logic [WIDTH-1:0] exp_nxt;
  logic             ovf_nxt;

  // >= / <= pull the count back into the window when min/max move past it
  always_comb begin
    exp_nxt = exp_cnt;
    ovf_nxt = 1'b0;
    if (load) begin
      exp_nxt = init;
    end else if (en && !dir) begin
      if (exp_cnt >= max_v) begin
        exp_nxt = min_v;
        ovf_nxt = 1'b1;
      end else begin
        exp_nxt = exp_cnt + WIDTH'(1);
      end
    end else if (en && dir) begin
      if (exp_cnt <= min_v) begin
        exp_nxt = max_v;
        ovf_nxt = 1'b1;
      end else begin
        exp_nxt = exp_cnt - WIDTH'(1);
      end
    end
  end

  assign mis_cnt = check && !cfg_bad && (dut_cnt != exp_cnt);
  assign mis_ovf = check && !cfg_bad && (dut_ovf != exp_ovf);

  always_ff @(posedge clk) begin
    if (rst) begin
      exp_cnt <= '0;
      exp_ovf <= 1'b0;
      cfg_bad <= 1'b0;
      err_cnt <= 1'b0;
      err_ovf <= 1'b0;
    end else begin
      exp_cnt <= exp_nxt;
      exp_ovf <= ovf_nxt;
      cfg_bad <= (min_v > max_v);
      err_cnt <= mis_cnt;
      err_ovf <= mis_ovf;
    end
  end
endmodule

module d_ip_timer_cnt_ref_checker #(
  parameter int WIDTH       = 8,
  parameter int CHANNELS    = 2,
  parameter int ERR_W       = 8,
  parameter int GRACE       = 2,
  parameter int STOP_ON_ERR = 0
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        arm,
  input  logic [CHANNELS-1:0]                         cnt_en,
  input  logic [CHANNELS-1:0]                         cnt_dir,
  input  logic [CHANNELS-1:0]                         load,
  input  logic [CHANNELS*WIDTH-1:0]                   cnt_init,
  input  logic [CHANNELS*WIDTH-1:0]                   cnt_min,
  input  logic [CHANNELS*WIDTH-1:0]                   cnt_max,
  input  logic [CHANNELS*WIDTH-1:0]                   dut_cnt,
  input  logic [CHANNELS-1:0]                         dut_ovf,
  output logic [CHANNELS*WIDTH-1:0]                   exp_cnt,
  output logic [CHANNELS-1:0]                         err_cnt,
  output logic [CHANNELS-1:0]                         err_ovf,
  output logic [CHANNELS-1:0]                         err_cfg,
  output logic [CHANNELS-1:0]                         err_sticky,
  output logic [ERR_W-1:0]                            err_total,
  output logic [((CHANNELS>1)?$clog2(CHANNELS):1)-1:0] first_err_ch,
  output logic [1:0]                                  state
);
  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_GRACE = 2'd1, S_CHECK = 2'd2, S_HALT = 2'd3} state_t;

  logic [CHANNELS-1:0][WIDTH-1:0] init_a, min_a, max_a, dut_a, exp_a;
  logic [CHANNELS-1:0]            exp_ovf_a, mis_cnt_a, mis_ovf_a;
  logic                           check_en, any_err;
  logic [CH_W-1:0]                first_idx;
  state_t                         state_q, state_nxt;
  logic [3:0]                     gcnt;

  assign init_a  = cnt_init;
  assign min_a   = cnt_min;
  assign max_a   = cnt_max;
  assign dut_a   = dut_cnt;
  assign exp_cnt = exp_a;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    d_ip_timer_cnt_ref_chan #(.WIDTH(WIDTH)) u_ch (
      .clk     (clk),
      .rst     (rst),
      .check   (check_en),
      .en      (cnt_en[c]),
      .dir     (cnt_dir[c]),
      .load    (load[c]),
      .init    (init_a[c]),
      .min_v   (min_a[c]),
      .max_v   (max_a[c]),
      .dut_cnt (dut_a[c]),
      .dut_ovf (dut_ovf[c]),
      .exp_cnt (exp_a[c]),
      .exp_ovf (exp_ovf_a[c]),
      .cfg_bad (err_cfg[c]),
      .mis_cnt (mis_cnt_a[c]),
      .mis_ovf (mis_ovf_a[c]),
      .err_cnt (err_cnt[c]),
      .err_ovf (err_ovf[c])
    );

`ifdef D_IP_TIMER_CHK_SVA_EN
    a_no_err_cnt: assert property (@(posedge clk) disable iff (rst) !err_cnt[c]);
    a_no_err_ovf: assert property (@(posedge clk) disable iff (rst) !err_ovf[c]);
    c_ovf_up: cover property (@(posedge clk) disable iff (rst)
      !load[c] && cnt_en[c] && !cnt_dir[c] && (exp_a[c] >= max_a[c]));
    c_ovf_dn: cover property (@(posedge clk) disable iff (rst)
      !load[c] && cnt_en[c] && cnt_dir[c] && (exp_a[c] <= min_a[c]));
`endif
  end

  assign any_err = |(mis_cnt_a | mis_ovf_a);

  // descending scan so the lowest flagged channel is the one left standing
  always_comb begin
    first_idx = '0;
    for (int c = CHANNELS - 1; c >= 0; c--)
      if (mis_cnt_a[c] || mis_ovf_a[c]) first_idx = CH_W'(c);
  end

  // grace counter is loaded while idle; GRACE of 0 or 1 both give one grace cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      gcnt    <= '0;
    end else begin
      state_q <= state_nxt;
      if (state_q == S_IDLE)                    gcnt <= 4'(GRACE);
      else if (state_q == S_GRACE && gcnt != 0) gcnt <= gcnt - 4'd1;
    end
  end

  always_comb begin
    state_nxt = state_q;
    if (!arm) begin
      state_nxt = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  state_nxt = S_GRACE;
        S_GRACE: if (gcnt <= 4'd1) state_nxt = S_CHECK;
        S_CHECK: if ((STOP_ON_ERR != 0) && any_err) state_nxt = S_HALT;
        default: state_nxt = state_q;
      endcase
    end
  end

  always_comb begin
    state    = state_q;
    check_en = (state_q == S_CHECK);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_sticky   <= '0;
      err_total    <= '0;
      first_err_ch <= '0;
    end else if (any_err) begin
      err_sticky <= err_sticky | mis_cnt_a | mis_ovf_a;
      if (err_total != {ERR_W{1'b1}}) err_total <= err_total + ERR_W'(1);
      if (err_sticky == '0) first_err_ch <= first_idx;
    end
  end
endmodule
